// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed seven-segment scan driver.
// Segment patterns are {g,f,e,d,c,b,a}, active high (lit = 1).
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  typedef logic [1:0] digit_idx_t;

  localparam logic [6:0] SEG_HEX_0 = 7'b0111111;
  localparam logic [6:0] SEG_HEX_1 = 7'b0000110;
  localparam logic [6:0] SEG_HEX_2 = 7'b1011011;
  localparam logic [6:0] SEG_HEX_3 = 7'b1001111;
  localparam logic [6:0] SEG_HEX_4 = 7'b1100110;
  localparam logic [6:0] SEG_HEX_5 = 7'b1101101;
  localparam logic [6:0] SEG_HEX_6 = 7'b1111101;
  localparam logic [6:0] SEG_HEX_7 = 7'b0000111;
  localparam logic [6:0] SEG_HEX_8 = 7'b1111111;
  localparam logic [6:0] SEG_HEX_9 = 7'b1101111;
  localparam logic [6:0] SEG_HEX_A = 7'b1110111;
  localparam logic [6:0] SEG_HEX_B = 7'b1111100;
  localparam logic [6:0] SEG_HEX_C = 7'b0111001;
  localparam logic [6:0] SEG_HEX_D = 7'b1011110;
  localparam logic [6:0] SEG_HEX_E = 7'b1111001;
  localparam logic [6:0] SEG_HEX_F = 7'b1110001;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to seven-segment pattern decoder.
// Output is active high; the caller inverts for common-anode pins.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_HEX_0;
    unique case (hex)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      4'hF: seg = SEG_HEX_F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode display scanner with frame-synchronous shadow
// capture, per-slot anti-ghosting guard and optional leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int GUARD    = 500
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic [3:0] Disp0,
  input  logic [3:0] Disp1,
  input  logic [3:0] Disp2,
  input  logic [3:0] Disp3,
  input  logic [3:0] DpIn,
  input  logic       Hold,
  input  logic       LzBlank,
  output logic [6:0] Seg,
  output logic       Dp,
  output logic [3:0] Anode,
  output logic       FrameTick
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] GUARD_V   = PW'(GUARD);

  if (SCAN_DIV < 2 || GUARD < 0 || GUARD >= SCAN_DIV) begin : g_bad_params
    $error("seg7_scan_driver: need SCAN_DIV >= 2 and 0 <= GUARD < SCAN_DIV");
  end

  logic [PW-1:0]  presc_q, presc_d;
  digit_idx_t     idx_q, idx_d;
  logic [3:0][3:0] shadow_q, shadow_d;
  logic [3:0]     dp_sh_q, dp_sh_d;
  logic [6:0]     seg_q, seg_d;
  logic           dp_q, dp_d;
  logic [3:0]     anode_q, anode_d;
  logic           frame_tick_q, frame_tick_d;

  logic           presc_wrap;
  logic           frame_wrap;
  logic [3:0]     cur_hex;
  logic [6:0]     cur_seg_hi;
  logic [3:0]     zero_from;
  logic           blank_cur;

  hex_to_seg7 u_dec (
    .hex (cur_hex),
    .seg (cur_seg_hi)
  );

  // zero_from[k]: shadow digits k..3 are all zero; digit 0 never blanks
  always_comb begin
    zero_from    = '0;
    zero_from[3] = (shadow_q[3] == 4'h0);
    zero_from[2] = zero_from[3] && (shadow_q[2] == 4'h0);
    zero_from[1] = zero_from[2] && (shadow_q[1] == 4'h0);
    zero_from[0] = 1'b0;
    blank_cur    = LzBlank && zero_from[idx_q];
  end

  always_comb begin
    presc_wrap   = (presc_q == PRESC_MAX);
    frame_wrap   = presc_wrap && (idx_q == digit_idx_t'(NUM_DIGITS - 1));
    presc_d      = presc_wrap ? '0 : presc_q + PW'(1);
    idx_d        = presc_wrap ? idx_q + 2'd1 : idx_q;
    shadow_d     = shadow_q;
    dp_sh_d      = dp_sh_q;
    frame_tick_d = frame_wrap;
    cur_hex      = shadow_q[idx_q];
    anode_d      = 4'b1111;
    seg_d        = SEG_OFF;
    dp_d         = 1'b1;

    if (frame_wrap && !Hold) begin
      shadow_d = {Disp3, Disp2, Disp1, Disp0};
      dp_sh_d  = DpIn;
    end

    if (presc_q >= GUARD_V) begin
      anode_d = ~(4'b0001 << idx_q);
      seg_d   = blank_cur ? SEG_OFF : ~cur_seg_hi;
      dp_d    = ~dp_sh_q[idx_q];
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      presc_q      <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      dp_sh_q      <= '0;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      anode_q      <= 4'b1111;
      frame_tick_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      dp_sh_q      <= dp_sh_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      anode_q      <= anode_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign Seg       = seg_q;
  assign Dp        = dp_q;
  assign Anode     = anode_q;
  assign FrameTick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with SCAN_DIV=8, GUARD=2.
// cyc counts posedges since reset release; pins after edge n show state n-1.
module tb_seg7_scan_driver;

  localparam int SD = 8;
  localparam int GD = 2;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic [3:0] Disp0 = '0, Disp1 = '0, Disp2 = '0, Disp3 = '0;
  logic [3:0] DpIn = '0;
  logic       Hold = 1'b0;
  logic       LzBlank = 1'b0;
  logic [6:0] Seg;
  logic       Dp;
  logic [3:0] Anode;
  logic       FrameTick;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  // active-low pins for hex 0..F, inverted from the decode table by hand
  logic [6:0] seg_t [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seg7_scan_driver #(.SCAN_DIV(SD), .GUARD(GD)) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .Disp0     (Disp0),
    .Disp1     (Disp1),
    .Disp2     (Disp2),
    .Disp3     (Disp3),
    .DpIn      (DpIn),
    .Hold      (Hold),
    .LzBlank   (LzBlank),
    .Seg       (Seg),
    .Dp        (Dp),
    .Anode     (Anode),
    .FrameTick (FrameTick)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    repeat (3) tick();
    Resetn = 1'b1;
    cyc = 0;
  endtask

  function automatic int slot_idx(int n);
    return ((n - 1) / SD) % 4;
  endfunction

  function automatic bit slot_lit(int n);
    return ((n - 1) % SD) >= GD;
  endfunction

  function automatic logic [3:0] exp_anode(int n);
    logic [3:0] a;
    a = 4'b1111;
    if (slot_lit(n)) a[slot_idx(n)] = 1'b0;
    return a;
  endfunction

  task automatic test_reset();
    Disp3 = 4'h9; Disp2 = 4'h9; Disp1 = 4'h9; Disp0 = 4'h9;
    DpIn = 4'b0000; Hold = 1'b0; LzBlank = 1'b0;
    do_reset();
    n_checks++;
    if (Anode !== 4'b1111 || Seg !== 7'b1111111 || Dp !== 1'b1 || FrameTick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_init: Anode=%b Seg=%b Dp=%b FT=%b want 1111 1111111 1 0",
               Anode, Seg, Dp, FrameTick);
    end
    repeat (45) tick();
    n_checks++;
    if (Anode !== 4'b1101 || Seg !== seg_t[9]) begin
      n_fail++;
      $display("FAIL reset_prescan: Anode=%b Seg=%b want 1101 %b", Anode, Seg, seg_t[9]);
    end
    Resetn = 1'b0;
    tick();
    n_checks++;
    if (Anode !== 4'b1111 || Seg !== 7'b1111111 || Dp !== 1'b1 || FrameTick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: Anode=%b Seg=%b Dp=%b FT=%b want 1111 1111111 1 0",
               Anode, Seg, Dp, FrameTick);
    end
    tick();
    tick();
    Resetn = 1'b1;
    cyc = 0;
    tick();
    n_checks++;
    if (Anode !== 4'b1111) begin
      n_fail++;
      $display("FAIL reset_guard: Anode=%b want 1111", Anode);
    end
    tick();
    tick();
    n_checks++;
    if (Anode !== 4'b1110 || Seg !== seg_t[0] || Dp !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_resume: Anode=%b Seg=%b Dp=%b want 1110 %b 1",
               Anode, Seg, Dp, seg_t[0]);
    end
  endtask

  task automatic test_scan();
    logic [6:0] es;
    logic ed;
    int i;
    Disp3 = 4'h4; Disp2 = 4'h3; Disp1 = 4'h2; Disp0 = 4'h1;
    DpIn = 4'b0001; Hold = 1'b0; LzBlank = 1'b0;
    do_reset();
    for (int n = 1; n <= 64; n++) begin
      tick();
      i = slot_idx(cyc);
      if (cyc <= 32) begin
        es = seg_t[0];
        ed = 1'b1;
      end else begin
        es = seg_t[i + 1];
        ed = (i != 0);
      end
      if (!slot_lit(cyc)) begin
        es = 7'b1111111;
        ed = 1'b1;
      end
      n_checks++;
      if (Anode !== exp_anode(cyc) || Seg !== es || Dp !== ed) begin
        n_fail++;
        $display("FAIL scan cyc=%0d: Anode=%b Seg=%b Dp=%b want %b %b %b",
                 cyc, Anode, Seg, Dp, exp_anode(cyc), es, ed);
      end
    end
  endtask

  task automatic test_hold();
    logic [15:0] val;
    logic [6:0] es;
    Disp3 = 4'hB; Disp2 = 4'hE; Disp1 = 4'hE; Disp0 = 4'hF;
    DpIn = 4'b0000; Hold = 1'b0; LzBlank = 1'b0;
    do_reset();
    repeat (32) tick();
    Hold = 1'b1;
    Disp3 = 4'h1; Disp2 = 4'h2; Disp1 = 4'h3; Disp0 = 4'h4;
    while (cyc < 192) begin
      tick();
      if (cyc == 140) Hold = 1'b0;
      val = (cyc <= 160) ? 16'hBEEF : 16'h1234;
      es = slot_lit(cyc) ? seg_t[val[slot_idx(cyc)*4 +: 4]] : 7'b1111111;
      n_checks++;
      if (Anode !== exp_anode(cyc) || Seg !== es) begin
        n_fail++;
        $display("FAIL hold cyc=%0d: Anode=%b Seg=%b want %b %b",
                 cyc, Anode, Seg, exp_anode(cyc), es);
      end
    end
  endtask

  task automatic test_blank();
    logic [6:0] es;
    int i;
    Disp3 = 4'h0; Disp2 = 4'h0; Disp1 = 4'h5; Disp0 = 4'h0;
    DpIn = 4'b0000; Hold = 1'b0; LzBlank = 1'b1;
    do_reset();
    repeat (32) tick();
    Disp1 = 4'h0;
    while (cyc < 96) begin
      tick();
      i = slot_idx(cyc);
      es = 7'b1111111;
      if (slot_lit(cyc)) begin
        if (i == 0) es = seg_t[0];
        else if (i == 1 && cyc <= 64) es = seg_t[5];
      end
      n_checks++;
      if (Anode !== exp_anode(cyc) || Seg !== es || Dp !== 1'b1) begin
        n_fail++;
        $display("FAIL blank cyc=%0d: Anode=%b Seg=%b Dp=%b want %b %b 1",
                 cyc, Anode, Seg, Dp, exp_anode(cyc), es);
      end
    end
  endtask

  task automatic test_frametick();
    int pulses;
    logic ef;
    pulses = 0;
    Hold = 1'b0; LzBlank = 1'b0;
    do_reset();
    while (cyc < 330) begin
      tick();
      ef = (cyc % 32 == 0) && (cyc <= 320);
      if (cyc > 320 && cyc % 32 == 0) ef = 1'b1;
      if (FrameTick === 1'b1 && cyc <= 320) pulses++;
      n_checks++;
      if (FrameTick !== ef) begin
        n_fail++;
        $display("FAIL frametick cyc=%0d: got %b want %b", cyc, FrameTick, ef);
      end
    end
    n_checks++;
    if (pulses != 10) begin
      n_fail++;
      $display("FAIL frametick_count: got %0d want 10", pulses);
    end
  endtask

  task automatic test_decode();
    Disp3 = 4'h0; Disp2 = 4'h0; Disp1 = 4'h0; Disp0 = 4'h0;
    DpIn = 4'b0000; Hold = 1'b0; LzBlank = 1'b0;
    do_reset();
    for (int v = 0; v < 16; v++) begin
      Disp0 = 4'(v);
      while (cyc < 32 * (v + 1) + 3) tick();
      n_checks++;
      if (Anode !== 4'b1110 || Seg !== seg_t[v] || Dp !== 1'b1) begin
        n_fail++;
        $display("FAIL decode v=%0h: Anode=%b Seg=%b Dp=%b want 1110 %b 1",
                 v, Anode, Seg, Dp, seg_t[v]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_hold();
    test_blank();
    test_frametick();
    test_decode();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
